// File: rtl/imem_loader_pkg.sv
// ARM ISA constants shared by the instruction-memory loader and its encoder.
// Op encodings, data-processing cmds, loader FSM states, cmd class helpers.
package arm_isa_pkg;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_TEQ = 4'b1001;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_AL = 4'hE;

  // Branch funct bits 25:24: I=1, L=0
  localparam logic [1:0] BR_FUNCT = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } loader_state_e;

  function automatic logic is_cmp(
    input logic [3:0] cmd
  );
    return cmd inside {CMD_TST, CMD_TEQ,
                       CMD_CMP, CMD_CMN};
  endfunction

  function automatic logic dp_cmd_ok(
    input logic [3:0] cmd
  );
    return cmd inside {CMD_AND, CMD_EOR,
                       CMD_SUB, CMD_ADD,
                       CMD_TST, CMD_TEQ,
                       CMD_CMP, CMD_CMN,
                       CMD_ORR, CMD_MOV};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Field-beat stream from the boot host into the loader.
// Master drives fields/valid/last, slave returns ready.
interface imem_loader_if;

  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [3:0]  in_cond;
  logic [1:0]  in_op;
  logic [5:0]  in_funct;
  logic [3:0]  in_rn;
  logic [3:0]  in_rd;
  logic [11:0] in_src2;
  logic [23:0] in_imm24;

  modport master (
    output in_valid,
    output in_last,
    output in_cond,
    output in_op,
    output in_funct,
    output in_rn,
    output in_rd,
    output in_src2,
    output in_imm24,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_last,
    input  in_cond,
    input  in_op,
    input  in_funct,
    input  in_rn,
    input  in_rd,
    input  in_src2,
    input  in_imm24,
    output in_ready
  );

endinterface

// File: rtl/imem_loader_encoder.sv
// Combinational fields -> 32-bit ARM word plus legality flag.
// Legality checks exist only when IMEM_LOADER_CHECK_EN is defined.
module imem_encoder
  import arm_isa_pkg::*;
(
  input  logic [3:0]  cond,
  input  logic [1:0]  op,
  input  logic [5:0]  funct,
  input  logic [3:0]  rn,
  input  logic [3:0]  rd,
  input  logic [11:0] src2,
  input  logic [23:0] imm24,
  output logic [31:0] word,
  output logic        legal
);

  logic [3:0] cmd;
  logic [3:0] rn_enc;

  assign cmd = funct[4:1];

  // MOV has no first operand; keep its Rn field clean
  assign rn_enc = (op == OP_DP && cmd == CMD_MOV)
                ? 4'h0 : rn;

  always_comb begin
    word = {cond, op, funct, rn_enc, rd, src2};
    if (op == OP_BR) begin
      word = {cond, OP_BR, BR_FUNCT, imm24};
    end
  end

`ifdef IMEM_LOADER_CHECK_EN
  always_comb begin
    legal = 1'b0;
    unique case (1'b1)
      op == OP_MEM,
      op == OP_BR: legal = 1'b1;
      op == OP_DP: legal = dp_cmd_ok(cmd) &&
                   !(is_cmp(cmd) && !funct[0]);
      default:     legal = 1'b0;
    endcase
  end
`else
  assign legal = 1'b1;
`endif

endmodule

// File: rtl/imem_loader.sv
// Streams encoded ARM words into instruction memory while the core idles.
// IMEM_LOADER_CHECK_EN enables dropping of illegal beats with err reporting.
module imem_loader
  import arm_isa_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  imem_loader_if.slave            in_if,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  output logic                    busy,
  output logic                    done,
  output logic                    full,
  output logic                    err,
  output logic                    err_sticky,
  output logic [$clog2(DEPTH):0]  word_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST_WC = CW'(DEPTH - 1);

  loader_state_e state;
  loader_state_e state_n;

  logic        accept;
  logic        wr;
  logic        last_wr;
  logic        restart;
  logic        legal;
  logic [31:0] word;
  logic [31:0] wr_addr;

  imem_encoder u_enc (
    .cond  (in_if.in_cond),
    .op    (in_if.in_op),
    .funct (in_if.in_funct),
    .rn    (in_if.in_rn),
    .rd    (in_if.in_rd),
    .src2  (in_if.in_src2),
    .imm24 (in_if.in_imm24),
    .word  (word),
    .legal (legal)
  );

  assign busy  = (state == S_LOAD);
  assign done  = (state == S_DONE);
  assign in_if.in_ready = busy && !full;

  assign accept  = in_if.in_valid && in_if.in_ready;
  assign wr      = accept && legal;
  assign last_wr = wr && (word_count == LAST_WC);
  assign restart = start && (state != S_LOAD);

  // Word index modulo DEPTH, scaled to bytes
  assign wr_addr = BASE + {{(30-AW){1'b0}},
                           word_count[AW-1:0],
                           2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_LOAD: begin
        if (accept && (in_if.in_last || last_wr)) begin
          state_n = S_DONE;
        end
      end
      default: begin
        if (start) begin
          state_n = S_LOAD;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we     <= 1'b0;
      mem_addr   <= BASE;
      mem_wdata  <= '0;
      full       <= 1'b0;
      word_count <= '0;
    end else begin
      mem_we <= wr;
      if (restart) begin
        mem_addr   <= BASE;
        full       <= 1'b0;
        word_count <= '0;
      end else if (wr) begin
        mem_addr   <= wr_addr;
        mem_wdata  <= word;
        word_count <= word_count + CW'(1);
        if (last_wr) begin
          full <= 1'b1;
        end
      end
    end
  end

`ifdef IMEM_LOADER_CHECK_EN
  logic drop;

  assign drop = accept && !legal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      err <= drop;
      if (restart) begin
        err_sticky <= 1'b0;
      end else if (drop) begin
        err_sticky <= 1'b1;
      end
    end
  end
`else
  assign err        = 1'b0;
  assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (DEPTH 4, BASE 0x1000).
// Table of encodings plus directed sessions; writes checked via scoreboard.
module tb_imem_loader;
  import arm_isa_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int NV = 14;

  typedef struct {
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic [23:0] imm24;
    logic        legal;
    logic [31:0] word;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        full;
  logic        err;
  logic        err_sticky;
  logic [2:0]  word_count;

  imem_loader_if bus ();

  imem_loader #(
    .DEPTH (DEPTH),
    .BASE  (BASE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_if      (bus),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .full       (full),
    .err        (err),
    .err_sticky (err_sticky),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] sb [$];
  vec_t vt [NV];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: addr %h data %h",
                 mem_addr, mem_wdata);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("wr_addr", mem_addr, e[63:32]);
        chk("wr_data", mem_wdata, e[31:0]);
      end
    end
  end

  function automatic logic eff_legal(input vec_t v);
`ifdef IMEM_LOADER_CHECK_EN
    return v.legal;
`else
    return 1'b1;
`endif
  endfunction

  task automatic drive(input vec_t v, input logic last);
    bus.in_cond  = v.cond;
    bus.in_op    = v.op;
    bus.in_funct = v.funct;
    bus.in_rn    = v.rn;
    bus.in_rd    = v.rd;
    bus.in_src2  = v.src2;
    bus.in_imm24 = v.imm24;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge after acceptance
  task automatic send(input vec_t v, input logic last,
                      input logic exp_wr,
                      input logic [31:0] addr);
    int t;
    t = 0;
    drive(v, last);
    while (bus.in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (bus.in_ready !== 1'b1) begin
      chk("ready_timeout", {31'b0, bus.in_ready}, 32'd1);
    end else if (exp_wr) begin
      sb.push_back({addr, v.word});
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, {31'b0, bus.in_ready}, 0);
    chk({tag, "_we"}, {31'b0, mem_we}, 0);
    chk({tag, "_addr"}, mem_addr, BASE);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_busy"}, {31'b0, busy}, 0);
    chk({tag, "_done"}, {31'b0, done}, 0);
    chk({tag, "_full"}, {31'b0, full}, 0);
    chk({tag, "_err"}, {31'b0, err}, 0);
    chk({tag, "_sticky"}, {31'b0, err_sticky}, 0);
    chk({tag, "_wc"}, {29'b0, word_count}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t limit 100000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int acc;
    logic e;

    vt[0]  = '{4'hE, 2'b00, 6'b101000, 4'd2, 4'd1,
               12'h005, 24'h0, 1'b1, 32'hE2821005};
    vt[1]  = '{4'hE, 2'b10, 6'b111111, 4'd0, 4'd0,
               12'h000, 24'hFFFFFE, 1'b1, 32'hEAFFFFFE};
    vt[2]  = '{4'hE, 2'b00, 6'b111010, 4'd3, 4'd4,
               12'h0FF, 24'h0, 1'b1, 32'hE3A040FF};
    vt[3]  = '{4'hE, 2'b00, 6'b010100, 4'd3, 4'd0,
               12'h001, 24'h0, 1'b0, 32'hE1430001};
    vt[4]  = '{4'hE, 2'b00, 6'b010101, 4'd3, 4'd0,
               12'h001, 24'h0, 1'b1, 32'hE1530001};
    vt[5]  = '{4'hE, 2'b01, 6'b011001, 4'd1, 4'd2,
               12'h004, 24'h0, 1'b1, 32'hE5912004};
    vt[6]  = '{4'h0, 2'b01, 6'b011000, 4'd5, 4'd6,
               12'h010, 24'h0, 1'b1, 32'h05856010};
    vt[7]  = '{4'hE, 2'b11, 6'b000000, 4'd1, 4'd1,
               12'h000, 24'h0, 1'b0, 32'hEC011000};
    vt[8]  = '{4'hE, 2'b00, 6'b000110, 4'd1, 4'd2,
               12'h003, 24'h0, 1'b0, 32'hE0612003};
    vt[9]  = '{4'h1, 2'b00, 6'b011000, 4'd7, 4'd8,
               12'h123, 24'h0, 1'b1, 32'h11878123};
    vt[10] = '{4'hB, 2'b10, 6'b000000, 4'd0, 4'd0,
               12'h000, 24'h000010, 1'b1, 32'hBA000010};
    vt[11] = '{4'hE, 2'b00, 6'b000101, 4'd9, 4'hA,
               12'hFFF, 24'h0, 1'b1, 32'hE059AFFF};
    vt[12] = '{4'hE, 2'b00, 6'b010000, 4'd1, 4'd0,
               12'h000, 24'h0, 1'b0, 32'hE1010000};
    vt[13] = '{4'hE, 2'b00, 6'b000010, 4'd3, 4'd4,
               12'h005, 24'h0, 1'b1, 32'hE0234005};

    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    drive(vt[0], 1'b0);
    bus.in_valid = 1'b0;

    repeat (3) @(negedge clk);
    chk_reset("rst");
    reset = 1'b1;
    @(negedge clk);

    // start and valid together in IDLE: no acceptance
    start = 1'b1;
    drive(vt[0], 1'b0);
    chk("idle_ready", {31'b0, bus.in_ready}, 0);
    @(negedge clk);
    start = 1'b0;
    bus.in_valid = 1'b0;
    chk("sv_wc", {29'b0, word_count}, 0);
    chk("sv_busy", {31'b0, busy}, 1);
    send(vt[0], 1'b0, 1'b1, BASE);
    chk("wc_one", {29'b0, word_count}, 1);
    do_start();
    chk("load_start_wc", {29'b0, word_count}, 1);
    chk("load_start_busy", {31'b0, busy}, 1);
    send(vt[1], 1'b1, 1'b1, BASE + 32'd4);
    chk("seq_done", {31'b0, done}, 1);
    chk("seq_wc", {29'b0, word_count}, 2);
    chk("seq_ready", {31'b0, bus.in_ready}, 0);

    for (int i = 0; i < NV; i++) begin
      v = vt[i];
      e = eff_legal(v);
      do_start();
      send(v, 1'b1, e, BASE);
      chk($sformatf("v%0d_done", i), {31'b0, done}, 1);
      chk($sformatf("v%0d_wc", i),
          {29'b0, word_count}, {31'b0, e});
      chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, !e});
      chk($sformatf("v%0d_sticky", i),
          {31'b0, err_sticky}, {31'b0, !e});
      chk($sformatf("v%0d_full", i), {31'b0, full}, 0);
      @(negedge clk);
      chk($sformatf("v%0d_errpulse", i), {31'b0, err}, 0);
    end

    // dropped compare followed by a legal beat
    do_start();
    e = eff_legal(vt[3]);
    send(vt[3], 1'b0, e, BASE);
    send(vt[0], 1'b1, 1'b1, e ? BASE + 32'd4 : BASE);
    chk("drop_sticky", {31'b0, err_sticky}, {31'b0, !e});
    chk("drop_wc", {29'b0, word_count}, e ? 32'd2 : 32'd1);

    // back-to-back until full
    do_start();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      v = vt[0];
      v.rd = 4'(i);
      v.word = 32'hE2820005 | (32'(i) << 12);
      drive(v, 1'b0);
      if (bus.in_ready === 1'b1) begin
        sb.push_back({BASE + 32'(acc * 4), v.word});
        acc++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("full_acc", 32'(acc), 4);
    chk("full_flag", {31'b0, full}, 1);
    chk("full_done", {31'b0, done}, 1);
    chk("full_wc", {29'b0, word_count}, 4);
    chk("full_ready", {31'b0, bus.in_ready}, 0);

    // reset right after a beat is registered
    do_start();
    drive(vt[0], 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk_reset("mid");
    reset = 1'b1;
    @(negedge clk);
    do_start();
    send(vt[2], 1'b1, 1'b1, BASE);
    chk("restart_done", {31'b0, done}, 1);
    chk("restart_wc", {29'b0, word_count}, 1);

    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
